fifo_ctrl: RTL

Pointer and flag controller that sits directly upstream of the 8x10 FIFO memory and drives its wr_en, rd_en, wr_ptr and rd_ptr.
- Accepts push/pop requests from the transaction layer.
- Tracks occupancy and raises full, empty, almost-full, almost-empty and error flags.
- Provides a threshold-programming (INIT) state machine.
- Carries no data; the memory holds the 10-bit words.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_ptr.sv | 27 ++
 rtl/fifo_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and FSM encoding for the FIFO controller, memory and transaction layer.
package fifo_pkg;

    localparam int ADDR_WIDTH = 3;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam int AF_DEF     = 6;
    localparam int AE_DEF     = 1;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } fifo_state_e;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping address pointer: post-increments on inc, synchronous clear on clr.
module fifo_ptr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_reg;

    // Wrap from all-ones back to zero comes from natural W-bit overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg <= '0;
        end else if (clr) begin
            ptr_reg <= '0;
        end else if (inc) begin
            ptr_reg <= ptr_reg + W'(1);
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for the 8x10 FIFO memory with threshold-programming FSM.
// FIFO_CTRL_ERR_STICKY_EN: when defined, overflow/underflow latches the ERROR state until init.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
    parameter int AF_DEF     = fifo_pkg::AF_DEF,
    parameter int AE_DEF     = fifo_pkg::AE_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [ADDR_WIDTH:0]   umbral_alto,
    input  logic [ADDR_WIDTH:0]   umbral_bajo,
    input  logic                  push,
    input  logic                  pop,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error,
    output logic [2:0]            state
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] ZERO_C  = '0;

    fifo_state_e           state_reg, state_next;
    logic [ADDR_WIDTH:0]   count_reg, count_next;
    logic [ADDR_WIDTH:0]   af_thr_reg, af_thr_next;
    logic [ADDR_WIDTH:0]   ae_thr_reg, ae_thr_next;
    logic                  err_reg, err_next;
    logic                  ptr_clr;
    logic                  push_ok, pop_ok, overflow, underflow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_RESET;
            count_reg  <= '0;
            af_thr_reg <= (ADDR_WIDTH + 1)'(AF_DEF);
            ae_thr_reg <= (ADDR_WIDTH + 1)'(AE_DEF);
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            af_thr_reg <= af_thr_next;
            ae_thr_reg <= ae_thr_next;
            err_reg    <= err_next;
        end
    end

    assign full         = (count_reg == DEPTH_C);
    assign empty        = (count_reg == ZERO_C);
    assign almost_full  = (count_reg >= af_thr_reg);
    assign almost_empty = (count_reg <= ae_thr_reg);
    assign push_ok      = push & ~full;
    assign pop_ok       = pop & ~empty;
    assign overflow     = push & full;
    assign underflow    = pop & empty;

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        af_thr_next = af_thr_reg;
        ae_thr_next = ae_thr_reg;
        err_next    = 1'b0;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        ptr_clr     = 1'b0;
        case (state_reg)
            ST_RESET: state_next = ST_INIT;
            ST_INIT: begin
                if (init) begin
                    ptr_clr     = 1'b1;
                    count_next  = '0;
                    af_thr_next = umbral_alto;
                    ae_thr_next = umbral_bajo;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE, ST_ACTIVE: begin
                if (init) begin
                    // Contents are discarded simply by clearing both pointers.
                    state_next = ST_INIT;
                    ptr_clr    = 1'b1;
                    count_next = '0;
                end else begin
                    wr_en      = push_ok;
                    rd_en      = pop_ok;
                    count_next = count_reg + {{ADDR_WIDTH{1'b0}}, push_ok}
                                           - {{ADDR_WIDTH{1'b0}}, pop_ok};
                    state_next = (count_next != ZERO_C) ? ST_ACTIVE : ST_IDLE;
`ifdef FIFO_CTRL_ERR_STICKY_EN
                    if (overflow | underflow) begin
                        state_next = ST_ERROR;
                        err_next   = 1'b1;
                    end
`else
                    err_next = overflow | underflow;
`endif
                end
            end
            ST_ERROR: begin
                if (init) begin
                    state_next = ST_INIT;
                    ptr_clr    = 1'b1;
                    count_next = '0;
                end else begin
                    err_next = 1'b1;
                end
            end
            default: state_next = ST_RESET;
        endcase
    end

    fifo_ptr #(.W(ADDR_WIDTH)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (ptr_clr),
        .inc   (wr_en),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.W(ADDR_WIDTH)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (ptr_clr),
        .inc   (rd_en),
        .ptr   (rd_ptr)
    );

    assign count = count_reg;
    assign error = err_reg;
    assign state = state_reg;

endmodule
